// File: rtl/fir4_rca.sv
// 4-tap unsigned moving-sum FIR: registered tap line feeding a tree of
// structural ripple-carry adders, with a registered (w+2)-bit sum.

module fir4_fa (
   input  logic x_i,
   input  logic y_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = x_i ^ y_i ^ ci_i;
   assign co_o = (x_i & y_i) | (x_i & ci_i) | (y_i & ci_i);
endmodule

// n-bit ripple-carry adder; the final carry becomes the result MSB.
module fir4_rca_add #(
   parameter int n = 4
) (
   input  logic [n-1:0] x_i,
   input  logic [n-1:0] y_i,
   output logic [n:0]   sum_o
);
   logic [n:0]   c_s;
   logic [n-1:0] s_s;

   assign c_s[0] = 1'b0;

   for (genvar i = 0; i < n; i++) begin : g_cell
      fir4_fa u_fa (
         .x_i  (x_i[i]),
         .y_i  (y_i[i]),
         .ci_i (c_s[i]),
         .s_o  (s_s[i]),
         .co_o (c_s[i+1])
      );
   end

   assign sum_o = {c_s[n], s_s};
endmodule

module fir4_rca #(
   parameter int w = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [w-1:0]   a,
   output logic [w+1:0]   s
);
   logic [w-1:0] ar_q, br_q, cr_q, dr_q;
   logic [w:0]   p_s, q_s;
   logic [w+1:0] s_d, s_q;

   fir4_rca_add #(.n(w)) u_add_p (
      .x_i   (ar_q),
      .y_i   (br_q),
      .sum_o (p_s)
   );

   fir4_rca_add #(.n(w)) u_add_q (
      .x_i   (cr_q),
      .y_i   (dr_q),
      .sum_o (q_s)
   );

   // Final stage sums the two partial sums; its carry-out is the sum MSB.
   fir4_rca_add #(.n(w+1)) u_add_s (
      .x_i   (p_s),
      .y_i   (q_s),
      .sum_o (s_d)
   );

   // Tap delay line and output register; reset discards all history.
   always_ff @(posedge clk) begin
      if (reset) begin
         ar_q <= '0;
         br_q <= '0;
         cr_q <= '0;
         dr_q <= '0;
         s_q  <= '0;
      end else begin
         ar_q <= a;
         br_q <= ar_q;
         cr_q <= br_q;
         dr_q <= cr_q;
         s_q  <= s_d;
      end
   end

   assign s = s_q;
endmodule

// File: tb/tb_fir4_rca.sv
// Self-checking bench for fir4_rca at w=4 and w=16 against a sample-history
// moving-sum model.

module tb_fir4_rca;
   logic        clk;
   logic        reset;
   logic [3:0]  a4;
   logic [15:0] a16;
   logic [5:0]  s4;
   logic [17:0] s16;

   int errors;
   int checks;

   // model: last four captured samples, most recent first
   int h4[4];
   int h16[4];
   int e4;
   int e16;

   fir4_rca #(.w(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .a     (a4),
      .s     (s4)
   );

   fir4_rca #(.w(16)) dut16 (
      .clk   (clk),
      .reset (reset),
      .a     (a16),
      .s     (s16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge: the model's new sum uses only samples captured before it.
   task automatic tick();
      int n4;
      int n16;
      n4  = 0;
      n16 = 0;
      if (!reset) begin
         n4  = h4[0] + h4[1] + h4[2] + h4[3];
         n16 = h16[0] + h16[1] + h16[2] + h16[3];
      end
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            h4[i]  = 0;
            h16[i] = 0;
         end
      end else begin
         for (int i = 3; i > 0; i--) begin
            h4[i]  = h4[i-1];
            h16[i] = h16[i-1];
         end
         h4[0]  = int'(a4);
         h16[0] = int'(a16);
      end
      e4  = n4;
      e16 = n16;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      a4    = 4'hF;
      a16   = 16'hFFFF;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (s4 !== 6'd0) begin
            errors++;
            $display("FAIL reset_hold4 edge %0d: got %0d expected 0", i, s4);
         end
         checks++;
         if (s16 !== 18'd0) begin
            errors++;
            $display("FAIL reset_hold16 edge %0d: got %0d expected 0", i, s16);
         end
      end
      reset = 1'b0;
      a4    = 4'h0;
      a16   = 16'h0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (s4 !== 6'd0 || s16 !== 18'd0) begin
            errors++;
            $display("FAIL reset_release edge %0d: got %0d/%0d expected 0/0", i, s4, s16);
         end
      end
   endtask

   task automatic test_step();
      int exp_seq[7];
      exp_seq = '{0, 1, 2, 3, 4, 4, 4};
      reset = 1'b1;
      tick();
      reset = 1'b0;
      a4    = 4'd1;
      a16   = 16'd1;
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++;
         if (s4 !== 6'(exp_seq[i]) || s16 !== 18'(exp_seq[i])) begin
            errors++;
            $display("FAIL step edge %0d: got %0d/%0d expected %0d", i, s4, s16, exp_seq[i]);
         end
      end
   endtask

   task automatic test_impulse();
      int exp_seq[6];
      exp_seq = '{5, 5, 5, 5, 0, 0};
      reset = 1'b1;
      tick();
      reset = 1'b0;
      a4    = 4'd5;
      a16   = 16'd5;
      tick();
      checks++;
      if (s4 !== 6'd0) begin
         errors++;
         $display("FAIL impulse_capture: got %0d expected 0", s4);
      end
      a4  = 4'd0;
      a16 = 16'd0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (s4 !== 6'(exp_seq[i]) || s16 !== 18'(exp_seq[i])) begin
            errors++;
            $display("FAIL impulse edge k+%0d: got %0d/%0d expected %0d", i + 1, s4, s16, exp_seq[i]);
         end
      end
   endtask

   task automatic test_max();
      a4  = 4'hF;
      a16 = 16'hFFFF;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (s4 !== 6'(e4) || s16 !== 18'(e16)) begin
            errors++;
            $display("FAIL max_model edge %0d: got %0d/%0d expected %0d/%0d", i, s4, s16, e4, e16);
         end
      end
      checks++;
      if (s4 !== 6'h3C) begin
         errors++;
         $display("FAIL max_w4: got %0h expected 3c", s4);
      end
      checks++;
      if (s16 !== 18'h3FFFC) begin
         errors++;
         $display("FAIL max_w16: got %0h expected 3fffc", s16);
      end
   endtask

   task automatic test_mid_reset();
      int exp_seq[5];
      exp_seq = '{0, 3, 6, 9, 12};
      reset = 1'b1;
      a4    = 4'd3;
      a16   = 16'd3;
      tick();
      checks++;
      if (s4 !== 6'd0 || s16 !== 18'd0) begin
         errors++;
         $display("FAIL mid_reset_edge: got %0d/%0d expected 0/0", s4, s16);
      end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (s4 !== 6'(exp_seq[i]) || s16 !== 18'(exp_seq[i])) begin
            errors++;
            $display("FAIL mid_reset_ramp edge %0d: got %0d/%0d expected %0d", i, s4, s16, exp_seq[i]);
         end
      end
   endtask

   task automatic test_random();
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         a4  = 4'($urandom_range(0, 15));
         a16 = 16'($urandom_range(0, 65535));
         tick();
         checks++;
         if (s4 !== 6'(e4)) begin
            errors++;
            $display("FAIL random_w4 cycle %0d: got %0d expected %0d", i, s4, e4);
         end
         checks++;
         if (s16 !== 18'(e16)) begin
            errors++;
            $display("FAIL random_w16 cycle %0d: got %0d expected %0d", i, s16, e16);
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      e4     = 0;
      e16    = 0;
      for (int i = 0; i < 4; i++) begin
         h4[i]  = 0;
         h16[i] = 0;
      end
      reset = 1'b1;
      a4    = 4'h0;
      a16   = 16'h0;
      test_reset();
      test_step();
      test_impulse();
      test_max();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
